hazard_ctrl: RTL and testbench

Pipeline hazard and forwarding controller for the five-stage RV32I core. It keeps its own scoreboard of the destination registers in flight in EX, MEM and WB. From that scoreboard it drives the forwarding selects and data (`rD1_op/rD2_op/rD1_forward/rD2_forward`) of the ID/EX pipeline register, the load-use stall of PC and IF/ID, and the `flush` of IF/ID and ID/EX on a taken branch or jump. It also keeps saturating stall/flush event counters for trace debug.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/fwd_sel.sv | 37 +++
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the RV32I pipeline control: writeback selects, hazard FSM
// states and the scoreboard entry used to track in-flight destinations.
package pipe_pkg;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_DRAM = 2'd1;
    localparam logic [1:0] WD_PC4  = 2'd2;
    localparam logic [1:0] WD_IMM  = 2'd3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] wR;
        logic       we;
        logic       is_load;
    } sb_entry_t;

    // A source hits an entry only if it is really read and is not x0.
    function automatic logic srcHit(input sb_entry_t e, input logic re, input logic [4:0] rs);
        return re && (rs != 5'd0) && e.valid && e.we && (e.wR == rs);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-source forwarding select: youngest matching in-flight writer wins,
// EX over MEM over WB, using that stage's writeback value.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic        re_i,
    input  logic [4:0]  rs_i,
    input  sb_entry_t   ex_i,
    input  sb_entry_t   mem_i,
    input  sb_entry_t   wb_i,
    input  logic [31:0] ex_result_i,
    input  logic [31:0] mem_result_i,
    input  logic [31:0] wb_result_i,
    output logic        op_o,
    output logic [31:0] data_o
);

    // A load still in EX has no data yet; that case is resolved by the stall,
    // so it must also block forwarding of older (stale) values from MEM/WB.
    always_comb begin
        op_o   = 1'b0;
        data_o = 32'd0;
        if (srcHit(ex_i, re_i, rs_i)) begin
            if (!ex_i.is_load) begin
                op_o   = 1'b1;
                data_o = ex_result_i;
            end
        end else if (srcHit(mem_i, re_i, rs_i)) begin
            op_o   = 1'b1;
            data_o = mem_result_i;
        end else if (srcHit(wb_i, re_i, rs_i)) begin
            op_o   = 1'b1;
            data_o = wb_result_i;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage RV32I core: scoreboard
// of EX/MEM/WB destinations, load-use stall, redirect flush and debug counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_re1,
    input  logic             id_re2,
    input  logic [4:0]       id_wR,
    input  logic             id_rf_we,
    input  logic [1:0]       id_wd_sel,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_result,
    input  logic [31:0]      mem_result,
    input  logic [31:0]      wb_result,
    output logic             rD1_op,
    output logic             rD2_op,
    output logic [31:0]      rD1_forward,
    output logic [31:0]      rD2_forward,
    output logic             stall,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    sb_entry_t        ex_q, mem_q, wb_q, ex_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use, stall_int, flush_id_ex_int;
    logic             op1, op2;
    logic [31:0]      fwd1, fwd2;

    fwd_sel u_fwd_rs1 (
        .re_i(id_re1), .rs_i(id_rs1),
        .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q),
        .ex_result_i(ex_result), .mem_result_i(mem_result), .wb_result_i(wb_result),
        .op_o(op1), .data_o(fwd1)
    );

    fwd_sel u_fwd_rs2 (
        .re_i(id_re2), .rs_i(id_rs2),
        .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q),
        .ex_result_i(ex_result), .mem_result_i(mem_result), .wb_result_i(wb_result),
        .op_o(op2), .data_o(fwd2)
    );

    // Load-use is only raised from RUN so a held ID instruction stalls once;
    // a redirect in the same cycle squashes that instruction instead.
    always_comb begin
        load_use        = id_valid && (state_q == RUN) && ex_q.is_load &&
                          (srcHit(ex_q, id_re1, id_rs1) || srcHit(ex_q, id_re2, id_rs2));
        stall_int       = load_use && !ex_redirect;
        flush_id_ex_int = ex_redirect || load_use;

        state_d = RUN;
        if (ex_redirect) begin
            state_d = FLUSH;
        end else if (load_use) begin
            state_d = LU_STALL;
        end

        ex_d = '0;
        if (!flush_id_ex_int) begin
            ex_d.valid   = id_valid;
            ex_d.wR      = id_wR;
            ex_d.we      = id_rf_we;
            ex_d.is_load = (id_wd_sel == WD_DRAM);
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_int && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (ex_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Registered state still holds pre-reset values until the reset edge,
    // so every output is forced quiet while rst is high.
    always_comb begin
        rD1_op      = op1 && !rst;
        rD2_op      = op2 && !rst;
        rD1_forward = rst ? 32'd0 : fwd1;
        rD2_forward = rst ? 32'd0 : fwd2;
        stall       = stall_int && !rst;
        flush_if_id = ex_redirect && !rst;
        flush_id_ex = flush_id_ex_int && !rst;
        state_o     = rst ? 2'd0 : state_q;
        stall_cnt   = rst ? '0 : stall_cnt_q;
        flush_cnt   = rst ? '0 : flush_cnt_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: forwarding priority, x0,
// load-use stall, redirect, reset mid-stall and counter saturation.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs1, id_rs2, id_wR;
    logic             id_re1, id_re2, id_rf_we;
    logic [1:0]       id_wd_sel;
    logic             ex_redirect;
    logic [31:0]      ex_result, mem_result, wb_result;
    logic             rD1_op, rD2_op;
    logic [31:0]      rD1_forward, rD2_forward;
    logic             stall, flush_if_id, flush_id_ex;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int numChecks = 0;
    int numFails  = 0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_re1(id_re1), .id_re2(id_re2), .id_wR(id_wR),
        .id_rf_we(id_rf_we), .id_wd_sel(id_wd_sel),
        .ex_redirect(ex_redirect),
        .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
        .rD1_op(rD1_op), .rD2_op(rD2_op),
        .rD1_forward(rD1_forward), .rD2_forward(rD2_forward),
        .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .state_o(state_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are checked 2ns later,
    // well before the next rising edge.
    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic re1,
                                 input logic [4:0] rs2, input logic re2,
                                 input logic [4:0] wr, input logic we,
                                 input logic [1:0] wd, input logic redir);
        @(negedge clk);
        id_valid    = v;
        id_rs1      = rs1;
        id_re1      = re1;
        id_rs2      = rs2;
        id_re2      = re2;
        id_wR       = wr;
        id_rf_we    = we;
        id_wd_sel   = wd;
        ex_redirect = redir;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        assert (obs === exp) else begin
            numFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ex_result = 32'd0; mem_result = 32'd0; wb_result = 32'd0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, WD_ALU, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, WD_ALU, 0);
        checkOutput("rst_state", state_o, 0);
        checkOutput("rst_stall", stall, 0);

        // Reset released, empty scoreboard.
        @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("post_rst_op1", rD1_op, 0);
        checkOutput("post_rst_state", state_o, 0);
        checkOutput("post_rst_stall_cnt", stall_cnt, 0);
        checkOutput("post_rst_flush_cnt", flush_cnt, 0);

        // add x5 then sub reading x5 from EX.
        applyStimulus(1, 1, 1, 2, 1, 5, 1, WD_ALU, 0);
        checkOutput("first_inst_op1", rD1_op, 0);
        ex_result = 32'h11;
        applyStimulus(1, 5, 1, 3, 1, 7, 1, WD_ALU, 0);
        checkOutput("alu_dep_op1", rD1_op, 1);
        checkOutput("alu_dep_fwd1", rD1_forward, 32'h11);
        checkOutput("alu_dep_op2", rD2_op, 0);
        checkOutput("alu_dep_stall", stall, 0);

        // x5 written by three consecutive instructions, then read.
        applyStimulus(1, 0, 0, 0, 0, 5, 1, WD_ALU, 0);
        applyStimulus(1, 0, 0, 0, 0, 5, 1, WD_ALU, 0);
        applyStimulus(1, 0, 0, 0, 0, 5, 1, WD_IMM, 0);
        ex_result = 32'h22; mem_result = 32'h33; wb_result = 32'h44;
        applyStimulus(1, 0, 0, 5, 1, 0, 0, WD_ALU, 0);
        checkOutput("prio_ex_op2", rD2_op, 1);
        checkOutput("prio_ex_fwd2", rD2_forward, 32'h22);
        applyStimulus(1, 5, 1, 0, 0, 0, 0, WD_ALU, 0);
        checkOutput("prio_mem_op1", rD1_op, 1);
        checkOutput("prio_mem_fwd1", rD1_forward, 32'h33);
        applyStimulus(1, 5, 1, 0, 0, 0, 0, WD_ALU, 0);
        checkOutput("prio_wb_fwd1", rD1_forward, 32'h44);

        // In-flight write to x0 never forwards.
        applyStimulus(1, 0, 0, 0, 0, 0, 1, WD_ALU, 0);
        applyStimulus(1, 0, 1, 0, 1, 0, 0, WD_ALU, 0);
        checkOutput("x0_op1", rD1_op, 0);
        checkOutput("x0_op2", rD2_op, 0);

        // lw x6 then add reading x6.
        applyStimulus(1, 2, 1, 0, 0, 6, 1, WD_DRAM, 0);
        checkOutput("lw_issue_stall", stall, 0);
        applyStimulus(1, 6, 1, 1, 1, 8, 1, WD_ALU, 0);
        checkOutput("lu_stall", stall, 1);
        checkOutput("lu_flush_id_ex", flush_id_ex, 1);
        checkOutput("lu_flush_if_id", flush_if_id, 0);
        ex_result = 32'hBAD; mem_result = 32'hDEAD;
        applyStimulus(1, 6, 1, 1, 1, 8, 1, WD_ALU, 0);
        checkOutput("lu_state", state_o, 1);
        checkOutput("lu_second_stall", stall, 0);
        checkOutput("lu_second_flush", flush_id_ex, 0);
        checkOutput("lu_fwd_op1", rD1_op, 1);
        checkOutput("lu_fwd_data1", rD1_forward, 32'hDEAD);
        checkOutput("lu_stall_cnt", stall_cnt, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, WD_ALU, 0);
        checkOutput("lu_back_run", state_o, 0);

        // Redirect together with a load-use: redirect wins.
        applyStimulus(1, 0, 0, 0, 0, 9, 1, WD_DRAM, 0);
        applyStimulus(1, 9, 1, 0, 0, 10, 1, WD_ALU, 1);
        checkOutput("redir_flush_if_id", flush_if_id, 1);
        checkOutput("redir_flush_id_ex", flush_id_ex, 1);
        checkOutput("redir_stall", stall, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, WD_ALU, 1);
        checkOutput("redir_state", state_o, 2);
        checkOutput("redir_flush_cnt", flush_cnt, 1);
        checkOutput("redir_stall_cnt", stall_cnt, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, WD_ALU, 0);
        checkOutput("redir_again_state", state_o, 2);
        checkOutput("redir_again_cnt", flush_cnt, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, WD_ALU, 0);
        checkOutput("flush_to_run", state_o, 0);

        // Reset while in LU_STALL.
        applyStimulus(1, 0, 0, 0, 0, 6, 1, WD_DRAM, 0);
        applyStimulus(1, 6, 1, 0, 0, 8, 1, WD_ALU, 0);
        checkOutput("rst_lu_stall", stall, 1);
        applyStimulus(1, 6, 1, 0, 0, 8, 1, WD_ALU, 0);
        checkOutput("rst_lu_state_before", state_o, 1);
        checkOutput("rst_lu_cnt_before", stall_cnt, 2);
        rst = 1'b1;
        #1;
        checkOutput("in_rst_op1", rD1_op, 0);
        checkOutput("in_rst_state", state_o, 0);
        checkOutput("in_rst_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("after_rst_op1", rD1_op, 0);
        checkOutput("after_rst_state", state_o, 0);
        checkOutput("after_rst_stall_cnt", stall_cnt, 0);
        checkOutput("after_rst_flush_cnt", flush_cnt, 0);

        // Invalid ID behind a load never stalls.
        applyStimulus(1, 0, 0, 0, 0, 6, 1, WD_DRAM, 0);
        applyStimulus(0, 6, 1, 6, 1, 0, 0, WD_ALU, 0);
        checkOutput("invalid_id_stall", stall, 0);

        // Flush counter saturates at 2^CNT_W-1.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, WD_ALU, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, WD_ALU, 1);
        checkOutput("flush_cnt_14", flush_cnt, 14);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, WD_ALU, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, WD_ALU, 0);
        checkOutput("flush_cnt_sat", flush_cnt, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChecks, numFails);
        $finish;
    end

endmodule
